// File: rtl/key_generator_decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : g_function / key_generator_decrypt
//  Purpose  : AES-128 key schedule that delivers round keys K10 down to K0
//             for the decryption datapath, regenerating them by inverse steps.
//  Revision : 1.0  initial release
// ============================================================================

module g_function (
    input  logic [31:0] word,
    input  logic [7:0]  rcon,
    output logic [31:0] result
);

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_rot = {word[23:0], word[31:24]};

    // Byte x sits at bit offset (255-x)*8 because row 0 is the most significant.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[gi*8 +: 8] = c_SBOX[{~w_rot[gi*8 +: 8], 3'b000} +: 8];
        end
    endgenerate

    assign result = w_sub ^ {rcon, 24'h000000};

endmodule

module key_generator_decrypt #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BLOCK_LENGTH-1:0] key,
    input  logic                    en,
    input  logic [3:0]              Round_Count,
    output logic [BLOCK_LENGTH-1:0] current_key,
    output logic                    key_valid,
    output logic                    busy,
    output logic                    ready
);

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_EXPAND = 2'd1,
        c_READY  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BLOCK_LENGTH-1:0] r_work_key;
    logic [BLOCK_LENGTH-1:0] r_last_key;
    logic [3:0]              r_exp_cnt;

    logic [31:0]             w_g_in;
    logic [31:0]             w_g_out;
    logic [3:0]              w_rcon_idx;
    logic [7:0]              w_rcon;
    logic [31:0]             w_f4, w_f5, w_f6, w_f7;
    logic [31:0]             w_i0, w_i1, w_i2, w_i3;
    logic [BLOCK_LENGTH-1:0] w_fwd_key;
    logic [BLOCK_LENGTH-1:0] w_inv_key;

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One g instance: forward uses w3 of the held key, inverse rebuilds w3 = w7 ^ w6.
    assign w_g_in     = (r_state == c_EXPAND) ? r_work_key[31:0]
                                              : (r_work_key[31:0] ^ r_work_key[63:32]);
    assign w_rcon_idx = (r_state == c_EXPAND) ? r_exp_cnt : (4'd11 - Round_Count);
    assign w_rcon     = rcon_of(w_rcon_idx);

    g_function u_g (
        .word   (w_g_in),
        .rcon   (w_rcon),
        .result (w_g_out)
    );

    assign w_f4      = r_work_key[127:96] ^ w_g_out;
    assign w_f5      = r_work_key[95:64]  ^ w_f4;
    assign w_f6      = r_work_key[63:32]  ^ w_f5;
    assign w_f7      = r_work_key[31:0]   ^ w_f6;
    assign w_fwd_key = {w_f4, w_f5, w_f6, w_f7};

    assign w_i3      = r_work_key[31:0]   ^ r_work_key[63:32];
    assign w_i2      = r_work_key[63:32]  ^ r_work_key[95:64];
    assign w_i1      = r_work_key[95:64]  ^ r_work_key[127:96];
    assign w_i0      = r_work_key[127:96] ^ w_g_out;
    assign w_inv_key = {w_i0, w_i1, w_i2, w_i3};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_work_key  <= '0;
            r_last_key  <= '0;
            r_exp_cnt   <= 4'd0;
            current_key <= '0;
            key_valid   <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
        end else if (start) begin
            r_work_key <= key;
            r_exp_cnt  <= 4'd1;
            r_state    <= c_EXPAND;
            key_valid  <= 1'b0;
            busy       <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    key_valid <= 1'b0;
                end
                c_EXPAND: begin
                    key_valid  <= 1'b0;
                    r_work_key <= w_fwd_key;
                    r_exp_cnt  <= r_exp_cnt + 4'd1;
                    if (r_exp_cnt == 4'd10) begin
                        r_last_key <= w_fwd_key;
                        r_exp_cnt  <= 4'd0;
                        r_state    <= c_READY;
                        busy       <= 1'b0;
                        ready      <= 1'b1;
                    end
                end
                c_READY: begin
                    key_valid <= en;
                    if (en) begin
                        if (Round_Count == 4'd0) begin
                            current_key <= r_last_key;
                            r_work_key  <= r_last_key;
                        end else if (Round_Count <= 4'd10) begin
                            current_key <= w_inv_key;
                            r_work_key  <= w_inv_key;
                        end
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_generator_decrypt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_key_generator_decrypt
//  Purpose  : Directed bench with an independent AES key-schedule model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_key_generator_decrypt;

    localparam logic [127:0] c_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_K9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] c_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         en = 1'b0;
    logic [3:0]   Round_Count = 4'd0;
    logic [127:0] current_key;
    logic         key_valid;
    logic         busy;
    logic         ready;

    int n_vec  = 0;
    int n_fail = 0;
    int cnt;

    key_generator_decrypt #(.BLOCK_LENGTH(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .en          (en),
        .Round_Count (Round_Count),
        .current_key (current_key),
        .key_valid   (key_valid),
        .busy        (busy),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic (GF(2^8) based) ----------------
    logic [7:0] sbox_t [0:255];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int xv = 0; xv < 256; xv++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(xv), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[xv] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [127:0] m_keys [0:10];
    logic [127:0] m_cur = '0;
    logic         m_valid = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_ready = 1'b0;
    int           m_phase = 0;
    int           m_left = 0;

    // Rounds are issued in order, so round r always means K(10-r).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cur = '0; m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b0;
            m_phase = 0; m_left = 0;
        end else if (start) begin
            for (int i = 0; i <= 10; i++) m_keys[i] = round_key(key, i);
            m_phase = 1; m_left = 10;
            m_busy = 1'b1; m_ready = 1'b0; m_valid = 1'b0;
        end else if (m_phase == 1) begin
            m_valid = 1'b0;
            m_left  = m_left - 1;
            if (m_left == 0) begin
                m_phase = 2; m_busy = 1'b0; m_ready = 1'b1;
            end
        end else if (m_phase == 2) begin
            m_valid = en;
            if (en && Round_Count <= 4'd10) m_cur = m_keys[10 - int'(Round_Count)];
        end else begin
            m_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk ("current_key", current_key, m_cur);
        chkb("key_valid", key_valid, m_valid);
        chkb("busy", busy, m_busy);
        chkb("ready", ready, m_ready);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic [127:0] k, input logic e, input logic [3:0] rc);
        start = s; key = k; en = e; Round_Count = rc;
        @(negedge clk);
        start = 1'b0; en = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 20) begin
            step(1'b0, '0, (n == 3), 4'd0);
            n++;
        end
    endtask

    initial begin
        build_sbox();
        chk("model_K10", round_key(c_FIPS, 10), c_K10);
        chk("model_K9",  round_key(c_FIPS, 9),  c_K9);
        chk("model_K1",  round_key(c_FIPS, 1),  c_K1);
        chk("model_zero_K10", round_key('0, 10), c_Z10);

        repeat (2) @(negedge clk);
        rst = 1'b1;

        step(1'b0, '0, 1'b1, 4'd0);
        chkb("idle_en_valid", key_valid, 1'b0);
        chk ("idle_en_key", current_key, '0);

        step(1'b1, c_FIPS, 1'b0, 4'd0);
        chkb("start_busy", busy, 1'b1);
        wait_ready(cnt);
        chki("latency", cnt, 10);

        step(1'b0, '0, 1'b1, 4'd0);
        chk ("round0_K10", current_key, c_K10);
        chkb("round0_valid", key_valid, 1'b1);
        step(1'b0, '0, 1'b1, 4'd1);
        chk ("round1_K9", current_key, c_K9);
        for (int r = 2; r <= 8; r++) step(1'b0, '0, 1'b1, 4'(r));
        step(1'b0, '0, 1'b1, 4'd9);
        chk ("round9_K1", current_key, c_K1);
        step(1'b0, '0, 1'b0, 4'd0);
        chkb("gap_valid", key_valid, 1'b0);
        step(1'b0, '0, 1'b1, 4'd10);
        chk ("round10_K0", current_key, c_FIPS);

        step(1'b0, '0, 1'b1, 4'd0);
        chk ("replay_K10", current_key, c_K10);
        chkb("replay_no_busy", busy, 1'b0);
        step(1'b0, '0, 1'b1, 4'd12);
        chkb("rc12_valid", key_valid, 1'b1);
        chk ("rc12_hold", current_key, c_K10);

        step(1'b1, c_FIPS, 1'b1, 4'd0);
        chkb("start_en_valid", key_valid, 1'b0);
        chkb("start_en_busy", busy, 1'b1);
        chkb("start_en_ready", ready, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0, 4'd0);
        step(1'b1, '0, 1'b0, 4'd0);
        wait_ready(cnt);
        chki("restart_latency", cnt, 10);
        step(1'b0, '0, 1'b1, 4'd0);
        chk ("zero_K10", current_key, c_Z10);
        step(1'b0, '0, 1'b1, 4'd1);
        step(1'b0, '0, 1'b1, 4'd2);

        step(1'b1, c_FIPS, 1'b0, 4'd0);
        repeat (3) step(1'b0, '0, 1'b0, 4'd0);
        #2 rst = 1'b0;
        #1;
        chk ("arst_key", current_key, '0);
        chkb("arst_valid", key_valid, 1'b0);
        chkb("arst_busy", busy, 1'b0);
        chkb("arst_ready", ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) step(1'b0, '0, 1'b0, 4'd0);
        chkb("post_rst_ready", ready, 1'b0);
        step(1'b1, c_FIPS, 1'b0, 4'd0);
        wait_ready(cnt);
        chki("post_rst_latency", cnt, 10);
        step(1'b0, '0, 1'b1, 4'd0);
        chk ("post_rst_K10", current_key, c_K10);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_generator_decrypt.md
Name: key_generator_decrypt

Overview:
AES-128 key schedule for the decryption datapath. It delivers round keys in reverse order: K10 first, then K9 down to K0, one key per enable cycle.
On `start` it expands the cipher key forward for 10 cycles to reach K10 and retains it. It then walks backward with the inverse expansion step, so only about 384 flip-flops are used instead of storing all 11 keys.
It sits beside the decryption round FSM, which drives `en` and `Round_Count` exactly as the encryption FSM drives the encryption key generator.

Parameters:
BLOCK_LENGTH, 128, key/round-key width; only 128 is supported.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse: latch `key` and begin forward expansion
key  input  BLOCK_LENGTH  cipher key K0; sampled only when start=1
en  input  1  request the next decryption round key (from the FSM)
Round_Count  input  4  decryption round index, 0..10; round r requests K(10-r)
current_key  output  BLOCK_LENGTH  current decryption round key
key_valid  output  1  high the cycle after an accepted `en`
busy  output  1  high while forward expansion runs
ready  output  1  high when K10 is held and `en` requests are accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; current_key=0; key_valid=0; busy=0; ready=0; internal regs (work_key, last_key, exp_cnt) = 0.
- Words: {w0,w1,w2,w3} = key[127:96], [95:64], [63:32], [31:0].
- Uses the existing `g_function` (RotWord + SubWord + Rcon). One instance is shared through an input mux, because the two directions are never active in the same cycle.
- Rcon(i), i=1..10: 01,02,04,08,10,20,40,80,1B,36; all other i give 00.
- Forward step, Kn from Kn-1 with Rcon(n):
  - w4 = w0 ^ g(w3)
  - w5 = w1 ^ w4
  - w6 = w2 ^ w5
  - w7 = w3 ^ w6
- Inverse step, Kn-1 from Kn={w4..w7} with Rcon(n):
  - w3 = w7 ^ w6
  - w2 = w6 ^ w5
  - w1 = w5 ^ w4
  - w0 = w4 ^ g(w3)
- FSM, IDLE:
  - start=1 → work_key <= key; exp_cnt <= 1; go to EXPAND.
  - en is ignored in IDLE (key_valid stays 0).
- FSM, EXPAND:
  - busy=1, ready=0.
  - Each cycle: work_key <= fwd(work_key, Rcon(exp_cnt)); exp_cnt increments.
  - When exp_cnt=10: last_key <= the result (K10); go to READY.
  - Latency: start in cycle 0 → ready=1 in cycle 11.
- FSM, READY (ready=1, busy=0). With en=1, key_valid <= 1 and:
  - Round_Count=0: current_key <= last_key (K10); work_key <= last_key.
  - Round_Count=r, 1..10: work_key <= inv(work_key, Rcon(11-r)); current_key <= the same value. Round 1 yields K9 (Rcon 36); round 10 yields K0.
  - Round_Count 11..15: key_valid <= 1, current_key and work_key held.
  - With en=0: key_valid <= 0; current_key held.
- Replay: Round_Count=0 may be reissued at any time in READY and restarts the sequence from last_key without re-expansion.
- The FSM is trusted to issue rounds in order 0,1,…,10. Out-of-order requests apply the inverse step to whatever work_key holds (no checking).
- start while in EXPAND or READY:
  - Restart: work_key <= key; exp_cnt <= 1; go to EXPAND; ready drops the next cycle.
  - start has priority over a simultaneous en; that en is dropped and key_valid <= 0.
- current_key keeps its last value through EXPAND.
- Reset asserted mid-expansion or mid-walk clears everything immediately. Outputs are not valid until a new start and expansion complete.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse → busy for 10 cycles, ready=1 at cycle 11; then en with Round_Count=0 → current_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_valid=1.
2. Continue en with Round_Count=1 → ac7766f319fadc2128d12941575c006e; Round_Count=9 → a0fafe1788542cb123a339392a6c7605; Round_Count=10 → 2b7e151628aed2a6abf7158809cf4f3c.
3. After round 10, en with Round_Count=0 again → K10 d014f9a8… reappears with no busy period; en with Round_Count=12 → key_valid=1, current_key unchanged.
4. en pulses in IDLE and during EXPAND → key_valid stays 0, current_key stays 0 or unchanged; start with simultaneous en in READY → key_valid=0, busy=1 next cycle.
5. Start a new key (all zeros) while in EXPAND at cycle 5 → expansion restarts; the Round_Count=0 key becomes b4ef5bcb3e92e21123e951cf6f8f188e.
6. Drop rst at cycle 4 of EXPAND, asynchronously between clock edges → all outputs 0 immediately; ready stays 0 until a new start plus 10 cycles.
